// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480 frame geometry, counter width and tile size.
package vga_timing_pkg;
  localparam int CNT_W            = 10;
  localparam int DEF_TOTAL_COLS   = 800;
  localparam int DEF_TOTAL_ROWS   = 525;
  localparam int DEF_ACTIVE_COLS  = 640;
  localparam int DEF_ACTIVE_ROWS  = 480;
  localparam int TILE_SHIFT       = 5;
  localparam int TILE_W           = CNT_W - TILE_SHIFT;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TILE_W-1:0] tile_t;

  // Wrapping increment used by both pixel counters.
  function automatic cnt_t cnt_wrap_inc(input cnt_t v, input cnt_t last);
    return (v == last) ? '0 : v + cnt_t'(1);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync bit and flags its rising edge (raw input high while the registered copy is low).
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic sync_o,
  output logic rise_o
);
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 1'b0;
    else       sync_q <= sync_i;
  end

  assign sync_o = sync_q;
  assign rise_o = sync_i & ~sync_q;
endmodule

// File: rtl/sync_to_count.sv
// Re-times HSync/VSync by one clock and derives column/row counters, frame-start and active flags.
// Optional tile index outputs are enabled with SYNC_TO_COUNT_TILE_EN.
module sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start,
`ifdef SYNC_TO_COUNT_TILE_EN
  output logic [TILE_W-1:0] o_Tile_Col,
  output logic [TILE_W-1:0] o_Tile_Row,
`endif
  output logic             o_Active
);
  localparam cnt_t COL_LAST = cnt_t'(TOTAL_COLS - 1);
  localparam cnt_t ROW_LAST = cnt_t'(TOTAL_ROWS - 1);
  localparam cnt_t ACT_COLS = cnt_t'(ACTIVE_COLS);
  localparam cnt_t ACT_ROWS = cnt_t'(ACTIVE_ROWS);

  logic hs_q;
  logic vs_rise;
  cnt_t col_q, col_d;
  cnt_t row_q, row_d;
  logic fs_q, fs_d;

  sync_edge_detect u_vs_edge (
    .clk_i  (i_Clk),
    .rst_i  (i_Rst),
    .sync_i (i_VSync),
    .sync_o (o_VSync),
    .rise_o (vs_rise)
  );

  // Frame start wins over the end-of-line wrap so counts land on 0/0 with the re-timed VSync.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    fs_d  = 1'b0;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
      fs_d  = 1'b1;
    end else begin
      col_d = cnt_wrap_inc(col_q, COL_LAST);
      if (col_q == COL_LAST) row_d = cnt_wrap_inc(row_q, ROW_LAST);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hs_q  <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      hs_q  <= i_HSync;
      col_q <= col_d;
      row_q <= row_d;
      fs_q  <= fs_d;
    end
  end

  assign o_HSync       = hs_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Frame_Start = fs_q;
  assign o_Active      = (col_q < ACT_COLS) && (row_q < ACT_ROWS);

`ifdef SYNC_TO_COUNT_TILE_EN
  assign o_Tile_Col = col_q[CNT_W-1:TILE_SHIFT];
  assign o_Tile_Row = row_q[CNT_W-1:TILE_SHIFT];
`endif
endmodule

// File: tb/tb_sync_to_count.sv
// Scoreboard bench for sync_to_count on a reduced 100x100 frame (64x80 active) to keep runs short.
module tb_sync_to_count;
  import vga_timing_pkg::*;

  localparam int TC = 100, TR = 100, AC = 64, AR = 80;

  logic clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0;
  logic       o_hs, o_vs, o_fs, o_act;
  logic [9:0] o_col, o_row;
`ifdef SYNC_TO_COUNT_TILE_EN
  logic [4:0] o_tc, o_tr;
`endif

  sync_to_count #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_HSync       (hs),
    .i_VSync       (vs),
    .o_HSync       (o_hs),
    .o_VSync       (o_vs),
    .o_Col_Count   (o_col),
    .o_Row_Count   (o_row),
    .o_Frame_Start (o_fs),
`ifdef SYNC_TO_COUNT_TILE_EN
    .o_Tile_Col    (o_tc),
    .o_Tile_Row    (o_tr),
`endif
    .o_Active      (o_act)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, fs_seen = 0;
  logic       m_hs = 1'b0, m_vs = 1'b0, m_fs = 1'b0;
  logic [9:0] m_col = '0, m_row = '0;
  logic [23:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pk(input logic h, v, input logic [9:0] c, r, input logic f);
    return {h, v, c, r, f, logic'((c < AC) && (r < AR))};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {o_hs, o_vs, o_col, o_row, o_fs, o_act};
  endfunction

  task automatic model_clear();
    m_hs = 1'b0; m_vs = 1'b0; m_fs = 1'b0; m_col = '0; m_row = '0;
    sb.delete();
  endtask

  // Drive one clock of raw sync; the reference model predicts the registered outputs.
  task automatic cyc(input logic h, input logic v);
    logic fsc;
    @(negedge clk);
    hs = h; vs = v;
    fsc = !m_vs && v;
    m_hs = h; m_vs = v;
    if (fsc) begin
      m_col = '0; m_row = '0; m_fs = 1'b1;
    end else begin
      m_fs = 1'b0;
      if (m_col == 10'(TC - 1)) begin
        m_col = '0;
        m_row = (m_row == 10'(TR - 1)) ? 10'd0 : m_row + 10'd1;
      end else m_col = m_col + 10'd1;
    end
    sb.push_back(pk(m_hs, m_vs, m_col, m_row, m_fs));
    @(posedge clk); #1;
    chk("scoreboard", dut_vec(), sb.pop_front());
`ifdef SYNC_TO_COUNT_TILE_EN
    chk("tiles", {o_tr, o_tc}, {m_row[9:5], m_col[9:5]});
`endif
    if (o_fs) fs_seen++;
  endtask

  task automatic run_to(input logic [9:0] c, input logic [9:0] r);
    int n = 0;
    while (!(m_col == c && m_row == r) && n < 30000) begin
      cyc(1'($urandom), 1'b0);
      n++;
    end
    chk("reach", {o_row, o_col}, {r, c});
  endtask

  initial begin
    #2;
    chk("reset", dut_vec(), pk(1'b0, 1'b0, 10'd0, 10'd0, 1'b0));

    @(posedge clk); #2 rst = 1'b0;
    cyc(1'b0, 1'b1);
    chk("fs_first", {o_fs, o_vs, o_row, o_col}, {1'b1, 1'b1, 20'd0});
    cyc(1'b1, 1'b0);
    chk("fs_next", {o_fs, o_col}, {1'b0, 10'd1});

    run_to(10'd98, 10'd10);
    cyc(1'b0, 1'b0);
    chk("col_last", {o_row, o_col}, {10'd10, 10'd99});
    cyc(1'b0, 1'b0);
    chk("line_wrap", {o_row, o_col}, {10'd11, 10'd0});

    run_to(10'd63, 10'd79);
    chk("act_corner", o_act, 1);
    cyc(1'b0, 1'b0);
    chk("act_col_out", o_act, 0);
    run_to(10'd0, 10'd80);
    chk("act_row_out", o_act, 0);
    run_to(10'd64, 10'd95);
`ifdef SYNC_TO_COUNT_TILE_EN
    chk("tile_64_95", {o_tr, o_tc}, {5'd2, 5'd2});
`endif

    run_to(10'd99, 10'd99);
    cyc(1'b0, 1'b0);
    chk("frame_wrap", {o_fs, o_row, o_col}, {1'b0, 20'd0});

    fs_seen = 0;
    repeat (3000) cyc(1'($urandom), 1'b1);
    chk("hold_pulses", fs_seen, 1);
    chk("hold_count", {o_row, o_col}, {10'd29, 10'd99});
    cyc(1'b0, 1'b0);

    run_to(10'd50, 10'd40);
    #2 rst = 1'b1;
    #1 chk("async_rst", dut_vec(), pk(1'b0, 1'b0, 10'd0, 10'd0, 1'b0));
    model_clear();
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) cyc(1'($urandom), 1'b0);
    chk("after_rst", o_col, 5);

    @(posedge clk); #2 rst = 1'b1; vs = 1'b1;
    model_clear();
    @(posedge clk); #2 rst = 1'b0;
    cyc(1'b0, 1'b1);
    chk("rel_vs_high", {o_fs, o_row, o_col}, {1'b1, 20'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_to_count.md
# sync_to_count

Timing-recovery block for the VGA pipeline. It takes the raw HSync/VSync pair from the sync generator and re-times it by one clock. It produces pixel column/row counters aligned to that re-timed sync, plus frame-start, active-area and 32-pixel tile indices. Game logic (player control, collision, background renderer) uses these to decide what to draw at each pixel.

## Interface
- TOTAL_COLS, 800, pixel clocks per line (column counter modulus)
- TOTAL_ROWS, 525, lines per frame (row counter modulus)
- ACTIVE_COLS, 640, visible columns, indices 0..ACTIVE_COLS-1
- ACTIVE_ROWS, 480, visible rows, indices 0..ACTIVE_ROWS-1
- i_Clk  in  1  pixel clock; all state updates on rising edge
- i_Rst  in  1  reset, asynchronous, active-high
- i_HSync  in  1  raw horizontal sync
- i_VSync  in  1  raw vertical sync
- o_HSync  out  1  i_HSync delayed one clock
- o_VSync  out  1  i_VSync delayed one clock
- o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
- o_Frame_Start  out  1  one-cycle pulse marking column 0 / row 0 of a frame
- o_Active  out  1  1 when col < ACTIVE_COLS and row < ACTIVE_ROWS
- o_Tile_Col  out  5  o_Col_Count[9:5] (present only with SYNC_TO_COUNT_TILE_EN)
- o_Tile_Row  out  5  o_Row_Count[9:5] (present only with SYNC_TO_COUNT_TILE_EN)

## Operation
- The frame-start condition is internal: (o_VSync == 0) and (i_VSync == 1), i.e. a rising edge of raw VSync against the registered copy.
- Every clock:
  - o_HSync <= i_HSync and o_VSync <= i_VSync.
  - If the frame-start condition holds: col <= 0, row <= 0, o_Frame_Start <= 1.
  - Otherwise o_Frame_Start <= 0 and:
    - if col == TOTAL_COLS-1: col <= 0, and row wraps (TOTAL_ROWS-1 -> 0) or row <= row+1;
    - else col <= col+1.
- Frame start has priority over counter wrap.
- VSync held high for many cycles resets the counters once only, on the first cycle.
- No frame-start condition is needed for counting. Without VSync edges, counters free-run and wrap at TOTAL_COLS/TOTAL_ROWS.
- o_Active is combinational from the registered counters.
- o_Tile_Col/o_Tile_Row are bit slices (divide by 32, floor).
- Arithmetic is unsigned 10-bit. Counters never exceed modulus-1.

## Timing
- Reset (async assert): o_HSync=0, o_VSync=0, counters=0, o_Frame_Start=0. o_Active=1 and tiles=0, as derived from the zero counters.
- Release is synchronous to i_Clk. If i_VSync=1 at the first clock after release, a frame start fires (counts stay 0, pulse=1).
- Latency: one clock from raw sync to o_HSync/o_VSync.
- Counters are aligned with the re-timed sync. On the cycle o_VSync first reads 1, counts read 0/0 and o_Frame_Start=1.
- Reset asserted mid-frame zeroes all registers immediately, without waiting for a clock edge.

## Configuration
- SYNC_TO_COUNT_TILE_EN defined: o_Tile_Col/o_Tile_Row ports and logic are present.
- Not defined: those ports are absent. All other behaviour is identical.

## Structure
- Shared package vga_timing_pkg:
  - default TOTAL/ACTIVE constants;
  - TILE_SHIFT = 5;
  - count width constant (10).
- One natural sub-module: sync_edge_detect. It registers a sync bit and emits its rising-edge qualifier. It is instantiated for VSync (and for HSync if a line-start output is added later).

## Test plan
- Reset, then i_VSync 0->1 -> next clock: o_VSync=1, col=0, row=0, o_Frame_Start=1; following clock col=1, pulse=0.
- Free run from col 798, row 10 -> col 799/row 10, then col 0/row 11.
- col 799, row 524, no VSync edge -> next clock col 0, row 0, o_Frame_Start=0.
- i_VSync held high 3000 cycles -> exactly one frame-start pulse; counters continue from 0 after it.
- o_Active:
  - col 639/row 479 -> 1;
  - col 640 -> 0;
  - row 480 -> 0.
- Tiles (TILE_EN): col 64, row 95 -> o_Tile_Col=2, o_Tile_Row=2.
- Mid-count reset: assert i_Rst at col 300, row 200 between clock edges -> outputs read 0 before the next edge.
